bouncing_square_gen: RTL and testbench

Animated test-pattern source for the 640x480 HDMI path. It consumes the raster coordinates and sync/enable strobes from the video signal generator, and moves a solid square that bounces off the screen edges. The square moves once per frame. The block outputs pipelined RGB plus matching delayed hsync/vsync/de, which feed the three TMDS encoders directly.

---
 rtl/video_pkg.sv | 36 +++
 rtl/square_axis_mover.sv | 64 ++++++
 rtl/bouncing_square_gen.sv | 139 +++++++++++++
 tb/tb_bouncing_square_gen.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants, colour types and FSM encoding for the bouncing-square pattern source.
package video_pkg;

  localparam int unsigned COORD_BITS  = 10;
  localparam int unsigned COLOUR_BITS = 8;
  localparam int unsigned H_RES       = 640;
  localparam int unsigned V_RES       = 480;

  typedef struct packed {
    logic [COLOUR_BITS-1:0] r;
    logic [COLOUR_BITS-1:0] g;
    logic [COLOUR_BITS-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_X = 2'd1,
    MOVE_Y = 2'd2
  } move_state_t;

  localparam rgb_t BG_COLOUR = '{r: 8'h00, g: 8'h00, b: 8'h8B};
  localparam rgb_t FG_WHITE  = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

  // Foreground palette walked by the bounce counter; entry 0 matches the fixed-white build.
  localparam rgb_t PALETTE [8] = '{
    '{r: 8'hFF, g: 8'hFF, b: 8'hFF},
    '{r: 8'hFF, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'hFF, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'hFF},
    '{r: 8'hFF, g: 8'hFF, b: 8'h00},
    '{r: 8'h00, g: 8'hFF, b: 8'hFF},
    '{r: 8'hFF, g: 8'h00, b: 8'hFF},
    '{r: 8'hFF, g: 8'h80, b: 8'h00}
  };

endpackage

// File: rtl/square_axis_mover.sv
// One axis of the bouncing square: position, direction and wall-bounce step logic.
module square_axis_mover
  import video_pkg::*;
#(
  parameter int unsigned RES     = H_RES,
  parameter int unsigned SQ_SIZE = 64,
  parameter int unsigned SPEED   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  output logic [COORD_BITS-1:0] q,
  output logic                  bounce_c
);

  localparam int unsigned W   = COORD_BITS + 1;
  localparam int unsigned LIM = RES - SQ_SIZE;

  logic                  d;
  logic                  d_next;
  logic [COORD_BITS-1:0] q_next;
  logic [W-1:0]          q_ext;
  logic [W-1:0]          q_up;

  // One extra bit of headroom so q+SPEED never wraps before the wall compare.
  assign q_ext = {1'b0, q};
  assign q_up  = q_ext + W'(SPEED);

  always_comb begin
    q_next   = q;
    d_next   = d;
    bounce_c = 1'b0;
    if (step) begin
      if (d) begin
        if (q_up >= W'(LIM)) begin
          q_next   = COORD_BITS'(LIM);
          d_next   = 1'b0;
          bounce_c = 1'b1;
        end else begin
          q_next = q_up[COORD_BITS-1:0];
        end
      end else begin
        if (q_ext <= W'(SPEED)) begin
          q_next   = '0;
          d_next   = 1'b1;
          bounce_c = 1'b1;
        end else begin
          q_next = q - COORD_BITS'(SPEED);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
      d <= 1'b1;
    end else begin
      q <= q_next;
      d <= d_next;
    end
  end

endmodule

// File: rtl/bouncing_square_gen.sv
// Bouncing-square test pattern with a 2-cycle RGB/strobe pipeline.
// Define COLOUR_CYCLE_EN to step the foreground through an 8-entry palette on every bounce.
module bouncing_square_gen
  import video_pkg::*;
#(
  parameter int unsigned H_RES   = video_pkg::H_RES,
  parameter int unsigned V_RES   = video_pkg::V_RES,
  parameter int unsigned SQ_SIZE = 64,
  parameter int unsigned SPEED   = 2
) (
  input  logic                   i_clk_pxl,
  input  logic                   i_rst,
  input  logic [COORD_BITS-1:0]  i_sx,
  input  logic [COORD_BITS-1:0]  i_sy,
  input  logic                   i_de,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_nf,
  output logic [COLOUR_BITS-1:0] o_r,
  output logic [COLOUR_BITS-1:0] o_g,
  output logic [COLOUR_BITS-1:0] o_b,
  output logic                   o_de,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_bounce
);

  localparam int unsigned W = COORD_BITS + 1;

  move_state_t           state;
  move_state_t           state_next;
  logic                  step_x_c;
  logic                  step_y_c;
  logic [COORD_BITS-1:0] qx;
  logic [COORD_BITS-1:0] qy;
  logic                  bounce_x_c;
  logic                  bounce_y_c;
  logic                  bounce_x_seen;
  logic                  inside_c;
  logic                  inside_s1;
  logic                  de_s1;
  logic                  hsync_s1;
  logic                  vsync_s1;
  rgb_t                  fg_c;
  rgb_t                  pix_c;

  always_ff @(posedge i_clk_pxl or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Per-frame update: x in MOVE_X, y in MOVE_Y; new-frame pulses are ignored while busy.
  always_comb begin
    state_next = state;
    step_x_c   = 1'b0;
    step_y_c   = 1'b0;
    case (state)
      IDLE:    if (i_nf) state_next = MOVE_X;
      MOVE_X:  begin step_x_c = 1'b1; state_next = MOVE_Y; end
      MOVE_Y:  begin step_y_c = 1'b1; state_next = IDLE;   end
      default: state_next = IDLE;
    endcase
  end

  square_axis_mover #(.RES(H_RES), .SQ_SIZE(SQ_SIZE), .SPEED(SPEED)) u_axis_x (
    .clk      (i_clk_pxl),
    .rst      (i_rst),
    .step     (step_x_c),
    .q        (qx),
    .bounce_c (bounce_x_c)
  );

  square_axis_mover #(.RES(V_RES), .SQ_SIZE(SQ_SIZE), .SPEED(SPEED)) u_axis_y (
    .clk      (i_clk_pxl),
    .rst      (i_rst),
    .step     (step_y_c),
    .q        (qy),
    .bounce_c (bounce_y_c)
  );

  // Remember an x bounce so a corner hit merges into a single pulse after the y step.
  always_ff @(posedge i_clk_pxl or posedge i_rst) begin
    if (i_rst) begin
      bounce_x_seen <= 1'b0;
      o_bounce      <= 1'b0;
    end else begin
      o_bounce <= step_y_c & (bounce_x_seen | bounce_y_c);
      if (step_x_c) bounce_x_seen <= bounce_x_c;
    end
  end

`ifdef COLOUR_CYCLE_EN
  logic [2:0] pal_idx;

  always_ff @(posedge i_clk_pxl or posedge i_rst) begin
    if (i_rst)         pal_idx <= 3'd0;
    else if (o_bounce) pal_idx <= pal_idx + 3'd1;
  end

  assign fg_c = PALETTE[pal_idx];
`else
  assign fg_c = FG_WHITE;
`endif

  assign inside_c = ({1'b0, i_sx} >= {1'b0, qx}) && ({1'b0, i_sx} < ({1'b0, qx} + W'(SQ_SIZE))) &&
                    ({1'b0, i_sy} >= {1'b0, qy}) && ({1'b0, i_sy} < ({1'b0, qy} + W'(SQ_SIZE)));

  always_comb begin
    pix_c = '0;
    if (de_s1) pix_c = inside_s1 ? fg_c : BG_COLOUR;
  end

  always_ff @(posedge i_clk_pxl or posedge i_rst) begin
    if (i_rst) begin
      inside_s1 <= 1'b0;
      de_s1     <= 1'b0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      o_r       <= '0;
      o_g       <= '0;
      o_b       <= '0;
      o_de      <= 1'b0;
      o_hsync   <= 1'b0;
      o_vsync   <= 1'b0;
    end else begin
      inside_s1 <= inside_c;
      de_s1     <= i_de;
      hsync_s1  <= i_hsync;
      vsync_s1  <= i_vsync;
      o_r       <= pix_c.r;
      o_g       <= pix_c.g;
      o_b       <= pix_c.b;
      o_de      <= de_s1;
      o_hsync   <= hsync_s1;
      o_vsync   <= vsync_s1;
    end
  end

endmodule

// File: tb/tb_bouncing_square_gen.sv
// Self-checking bench: a 640x480 instance plus a 480x480 instance whose square hits a true corner.
module tb_bouncing_square_gen;

  typedef struct packed {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } px_t;

  typedef struct {
    int          sx;
    int          sy;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vec_t;

  localparam int SQ  = 64;
  localparam int SPD = 2;
  localparam logic [23:0] BG    = 24'h00008B;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
`ifdef COLOUR_CYCLE_EN
  localparam logic [23:0] PAL_TAB [8] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                                          24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFF8000};
  localparam logic [23:0] FIRST_BOUNCE_FG = 24'hFF0000;
`else
  localparam logic [23:0] FIRST_BOUNCE_FG = 24'hFFFFFF;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] sx, sy;
  logic       de, hs, vs, nf;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic       de0, hs0, vs0, bn0, de1, hs1, vs1, bn1;
  px_t        a0, a1;

  assign a0 = {r0, g0, b0, de0, hs0, vs0};
  assign a1 = {r1, g1, b1, de1, hs1, vs1};

  bouncing_square_gen u_dut (
    .i_clk_pxl(clk), .i_rst(rst), .i_sx(sx), .i_sy(sy), .i_de(de), .i_hsync(hs),
    .i_vsync(vs), .i_nf(nf), .o_r(r0), .o_g(g0), .o_b(b0), .o_de(de0),
    .o_hsync(hs0), .o_vsync(vs0), .o_bounce(bn0)
  );

  bouncing_square_gen #(.H_RES(480)) u_sq (
    .i_clk_pxl(clk), .i_rst(rst), .i_sx(sx), .i_sy(sy), .i_de(de), .i_hsync(hs),
    .i_vsync(vs), .i_nf(nf), .o_r(r1), .o_g(g1), .o_b(b1), .o_de(de1),
    .o_hsync(hs1), .o_vsync(vs1), .o_bounce(bn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  vectors = 0;
  int  miscompares = 0;
  int  mqx [2], mqy [2], mpal [2];
  bit  mdx [2], mdy [2];
  int  limx [2] = '{576, 416};
  int  limy = 416;
  int  since_nf = 3;
  int  frames = 0;
  int  cnt0 = 0, cnt1 = 0;
  px_t pq0 [$], pq1 [$];
  bit  bq0 [$], bq1 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_fg(int i);
`ifdef COLOUR_CYCLE_EN
    return PAL_TAB[mpal[i]];
`else
    return (i >= 0) ? WHITE : WHITE;
`endif
  endfunction

  function automatic px_t model_px(int i, int x, int y, logic e, logic h, logic v);
    bit in;
    logic [23:0] c;
    in = (x >= mqx[i]) && (x < mqx[i] + SQ) && (y >= mqy[i]) && (y < mqy[i] + SQ);
    c  = !e ? 24'h0 : (in ? model_fg(i) : BG);
    return {c, e, h, v};
  endfunction

  // Reference axis motion: walk toward the wall, clamp and reverse on reaching it.
  function automatic void axis(inout int q, inout bit d, input int lim, output bit b);
    b = 1'b0;
    if (d && q + SPD >= lim)  begin q = lim; d = 1'b0; b = 1'b1; end
    else if (!d && q <= SPD)  begin q = 0;   d = 1'b1; b = 1'b1; end
    else                      q = d ? q + SPD : q - SPD;
  endfunction

  function automatic bit model_frame(int i);
    int q; bit d, bx, by;
    q = mqx[i]; d = mdx[i]; axis(q, d, limx[i], bx); mqx[i] = q; mdx[i] = d;
    q = mqy[i]; d = mdy[i]; axis(q, d, limy, by);    mqy[i] = q; mdy[i] = d;
    if (bx || by) mpal[i] = (mpal[i] + 1) % 8;
    return bx || by;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mqx[i] = 0; mqy[i] = 0; mdx[i] = 1'b1; mdy[i] = 1'b1; mpal[i] = 0;
    end
    since_nf = 3;
    frames = 0;
    pq0.delete(); pq1.delete(); bq0.delete(); bq1.delete();
  endtask

  // One clock of stimulus; outputs are compared against expectations queued 2 (pixel) or 3 (bounce) steps earlier.
  task automatic step_cycle(input int x, input int y, input logic e, input logic h, input logic v,
                            input logic n, input bit use_tab, input px_t t0, input px_t t1);
    bit b0, b1;
    px_t ex;
    sx = 10'(x); sy = 10'(y); de = e; hs = h; vs = v; nf = n;
    pq0.push_back(use_tab ? t0 : model_px(0, x, y, e, h, v));
    pq1.push_back(use_tab ? t1 : model_px(1, x, y, e, h, v));
    b0 = 1'b0; b1 = 1'b0;
    if (n && since_nf >= 3) begin
      since_nf = 0;
      frames++;
      b0 = model_frame(0);
      b1 = model_frame(1);
    end
    if (since_nf < 3) since_nf++;
    bq0.push_back(b0);
    bq1.push_back(b1);
    @(posedge clk); #1;
    if (pq0.size() == 2) begin ex = pq0.pop_front(); chk("pix0", 32'(a0), 32'(ex)); end
    if (pq1.size() == 2) begin ex = pq1.pop_front(); chk("pix1", 32'(a1), 32'(ex)); end
    if (bq0.size() == 3) chk("bounce0", 32'(bn0), 32'(bq0.pop_front()));
    if (bq1.size() == 3) chk("bounce1", 32'(bn1), 32'(bq1.pop_front()));
    cnt0 += int'(bn0);
    cnt1 += int'(bn1);
  endtask

  task automatic blank(input int n);
    repeat (n) step_cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic frame();
    step_cycle(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
    blank(3);
  endtask

  task automatic probe(input int x, input int y, input bit in0, input bit in1,
                       input logic [23:0] fg0, input logic [23:0] fg1);
    px_t t0, t1;
    t0 = {in0 ? fg0 : BG, 3'b100};
    t1 = {in1 ? fg1 : BG, 3'b100};
    step_cycle(x, y, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, t0, t1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_out0"}, {4'h0, a0, bn0}, 32'h0);
    chk({name, "_out1"}, {4'h0, a1, bn1}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; sx = '0; sy = '0; de = 0; hs = 0; vs = 0; nf = 0;
    model_reset();
    #1 check_zero("rst_async");
    repeat (2) begin @(posedge clk); #1; check_zero("rst_hold"); end
    rst = 1'b0;
  endtask

  vec_t ta [7];
  vec_t tb [6];

  initial begin
    int c0, c1;
    logic [23:0] fa, fb;
    rst = 0; sx = '0; sy = '0; de = 0; hs = 0; vs = 0; nf = 0;
    ta[0] = '{10, 10, 1'b1, 1'b0, 1'b0, WHITE};
    ta[1] = '{100, 10, 1'b1, 1'b0, 1'b0, BG};
    ta[2] = '{63, 63, 1'b1, 1'b1, 1'b0, WHITE};
    ta[3] = '{64, 63, 1'b1, 1'b0, 1'b1, BG};
    ta[4] = '{63, 64, 1'b1, 1'b0, 1'b0, BG};
    ta[5] = '{10, 10, 1'b0, 1'b1, 1'b1, 24'h0};
    ta[6] = '{0, 0, 1'b1, 1'b0, 1'b0, WHITE};
    tb[0] = '{1, 1, 1'b1, 1'b0, 1'b0, BG};
    tb[1] = '{2, 2, 1'b1, 1'b0, 1'b0, WHITE};
    tb[2] = '{65, 65, 1'b1, 1'b1, 1'b0, WHITE};
    tb[3] = '{66, 65, 1'b1, 1'b0, 1'b0, BG};
    tb[4] = '{65, 66, 1'b1, 1'b0, 1'b1, BG};
    tb[5] = '{2, 1, 1'b1, 1'b0, 1'b0, BG};

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      px_t t;
      t = {ta[i].rgb, ta[i].de, ta[i].hs, ta[i].vs};
      step_cycle(ta[i].sx, ta[i].sy, ta[i].de, ta[i].hs, ta[i].vs, 1'b0, 1'b1, t, t);
    end
    blank(2);
    frame();
    for (int i = 0; i < 6; i++) begin
      px_t t;
      t = {tb[i].rgb, tb[i].de, tb[i].hs, tb[i].vs};
      step_cycle(tb[i].sx, tb[i].sy, tb[i].de, tb[i].hs, tb[i].vs, 1'b0, 1'b1, t, t);
    end

    // Random strobes and coordinates against the model, no frame updates.
    for (int i = 0; i < 200; i++)
      step_cycle(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'b0, 1'b0, '0, '0);

    while (frames < 207) begin
      frame();
      repeat (2) step_cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1,
                            1'($urandom), 1'($urandom), 1'b0, 1'b0, '0, '0);
    end
    probe(414, 414, 1, 1, WHITE, WHITE);
    probe(413, 414, 0, 0, WHITE, WHITE);

    c0 = cnt0; c1 = cnt1;
    frame();
    chk("corner_pulses1", 32'(cnt1 - c1), 32'd1);
    chk("ybounce_pulses0", 32'(cnt0 - c0), 32'd1);
    probe(416, 416, 1, 1, FIRST_BOUNCE_FG, FIRST_BOUNCE_FG);
    probe(415, 416, 0, 0, WHITE, WHITE);
    frame();
    fa = model_fg(0); fb = model_fg(1);
    probe(414, 414, 0, 1, fa, fb);
    probe(418, 414, 1, 1, fa, fb);
    probe(413, 414, 0, 0, fa, fb);

    while (frames < 287) begin
      frame();
      repeat (2) step_cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b1,
                            1'($urandom), 1'($urandom), 1'b0, 1'b0, '0, '0);
    end
    fa = model_fg(0); fb = model_fg(1);
    probe(574, 258, 1, 0, fa, fb);
    probe(573, 258, 0, 0, fa, fb);
    c0 = cnt0; c1 = cnt1;
    frame();
    chk("wall_pulses0", 32'(cnt0 - c0), 32'd1);
    chk("wall_pulses1", 32'(cnt1 - c1), 32'd0);
    fa = model_fg(0); fb = model_fg(1);
    probe(576, 256, 1, 0, fa, fb);
    probe(575, 256, 0, 0, fa, fb);
    frame();
    probe(574, 254, 1, 0, fa, fb);
    probe(637, 254, 1, 0, fa, fb);
    probe(638, 254, 0, 0, fa, fb);

    // Reset while the FSM sits in MOVE_X.
    step_cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    do_reset();
    c0 = cnt0; c1 = cnt1;
    blank(6);
    chk("no_bounce_after_rst", 32'((cnt0 - c0) + (cnt1 - c1)), 32'd0);
    probe(0, 0, 1, 1, WHITE, WHITE);
    probe(64, 64, 0, 0, WHITE, WHITE);

    // A new-frame strobe held for three cycles moves the square only once.
    repeat (3) step_cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    blank(3);
    probe(1, 1, 0, 0, WHITE, WHITE);
    probe(2, 2, 1, 1, WHITE, WHITE);
    probe(65, 65, 1, 1, WHITE, WHITE);
    probe(66, 66, 0, 0, WHITE, WHITE);
    blank(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
